uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   UART receive front end of cv32e40x_soc. Sits directly downstream of the SoC
//   ser_rx pin, the line the testbench drives with send_byte_ser.
//   Deserialises 8N1 frames, validates start and stop bits, and buffers bytes in
//   a FWFT FIFO. The bus-side UART register block pops bytes via valid/ready.
// PARAMETERS
//   CLK_FREQ    25_000_000  core clock in Hz
//   BAUDRATE    115200      line rate in bit/s
//   FIFO_DEPTH  8           receive FIFO entries; power of two, >= 2
//   Derived: CLKS_PER_BIT = CLK_FREQ / BAUDRATE (integer division; 217 at defaults)
// PORTS
//   clk_i        in   1                         core clock; all logic on posedge
//   rst_i        in   1                         synchronous reset, active-high
//   ser_rx_i     in   1                         async serial input; idle high
//   rdata_o      out  8                         head-of-FIFO byte
//   rvalid_o     out  1                         FIFO not empty
//   rready_i     in   1                         consumer pops when rvalid_o && rready_i
//   level_o      out  $clog2(FIFO_DEPTH)+1      current FIFO occupancy
//   frame_err_o  out  1                         1-cycle pulse: stop bit sampled 0
//   overrun_o    out  1                         1-cycle pulse: good byte dropped, FIFO full
// BEHAVIOUR
//   Reset (rst_i=1 at posedge):
//     - Synchroniser flops forced to 1; FSM goes to IDLE; bit counter and clock
//       counter cleared; FIFO pointers and level cleared.
//     - Outputs: rvalid_o=0, level_o=0, frame_err_o=0, overrun_o=0, rdata_o=8'h00.
//     - Reset mid-frame abandons the frame; nothing is pushed.
//   Input sync: 2-flop synchroniser; rx_s is the second-stage output. All decisions use rx_s.
//   FSM (the clock counter cnt counts down to 0):
//     IDLE   rx_s==0 -> cnt=CLKS_PER_BIT/2-1, go to START.
//     START  at cnt==0: if rx_s==0, cnt=CLKS_PER_BIT-1, bit=0, go to DATA;
//            else (glitch) go to IDLE with no flag.
//     DATA   at cnt==0: shreg={rx_s,shreg[7:1]} (LSB first); cnt=CLKS_PER_BIT-1;
//            after bit 7, go to STOP.
//     STOP   at cnt==0: if rx_s==1, push shreg; else pulse frame_err_o and discard.
//            Go to IDLE in all cases.
//     - Sampling is mid-bit. Return to IDLE at mid-stop allows back-to-back frames.
//     - A break (line held low) gives one frame_err_o, then is re-detected as a
//       start after the line returns high... only if rx_s goes high and then low again.
//       IDLE waits for rx_s==1 before re-arming.
//   FIFO (first-word fall-through):
//     - rdata_o always shows the head entry. A push is visible on rvalid_o and
//       level_o the cycle after the stop sample.
//     - Pop happens when rvalid_o && rready_i. rready_i while empty is ignored.
//     - Push while full with no pop: byte dropped, overrun_o pulses, contents unchanged.
//     - Simultaneous push and pop while full: both succeed, level stays FIFO_DEPTH,
//       no overrun.
//     - Simultaneous push and pop while empty: the push is stored and the pop is
//       ignored (rvalid_o was 0).
//     - Pointers wrap modulo FIFO_DEPTH. level_o ranges 0..FIFO_DEPTH.
//   frame_err_o and overrun_o are never asserted together. The consumer sticks them in CSRs.
// TESTING (defaults: 217 clk/bit, 8680 ns/bit, 40 ns clk)
//   1. Send 0x68 with rready_i=0.
//      -> rvalid_o rises about 9.5 bit times after the start edge (+2 sync cycles);
//         rdata_o=0x68, level_o=1. Raise rready_i for 1 cycle -> rvalid_o=0, level_o=0.
//   2. Pulse ser_rx_i low for 50 clk, then hold high for 2 frames.
//      -> FSM returns to IDLE, no push, no frame_err_o.
//   3. Send 0xA5 with stop bit 0.
//      -> frame_err_o is high for exactly 1 cycle; level_o stays 0.
//   4. Send 9 bytes 0x01..0x09 back-to-back with rready_i=0.
//      -> level_o=8, overrun_o pulses once on byte 9.
//      Then drain -> 0x01..0x08 in order.
//   5. FIFO full; pop in the same cycle as the 9th stop sample.
//      -> level_o stays 8, no overrun, head=0x02, tail=0x09.
//   6. Assert rst_i during DATA of 0x3C, release, then send 0x00 and 0xFF back-to-back.
//      -> only 0x00 and 0xFF are received, no errors.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word fall-through receive FIFO.
// Line decisions use the synchronised rx_s; start, data and stop bits are sampled mid-bit.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ser_rx_i,
    output logic [7:0]                    rdata_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          frame_err_o,
    output logic                          overrun_o
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int LVL_W        = PTR_W + 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               armed_q, armed_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               rx_s, push_req, push, pop;

    assign rx_s = sync2_q;

    // armed_q blocks a new start until the line has been seen high, so a break is reported once.
    always_comb begin
        sync1_d     = ser_rx_i;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        armed_d     = armed_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!rx_s) begin
                    state_d = S_DATA;
                    cnt_d   = FULL_LOAD;
                    bit_d   = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_IDLE;
                    if (rx_s) begin
                        push_req = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop frees a slot in the same cycle, so push-while-full succeeds when paired with a pop.
    always_comb begin
        pop       = (level_q != '0) && rready_i;
        push      = push_req && ((level_q != DEPTH_L) || pop);
        overrun_d = push_req && (level_q == DEPTH_L) && !pop;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            armed_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            armed_q     <= armed_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign rvalid_o    = (level_q != '0);
    assign level_o     = level_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are serialised onto ser_rx_i, expected bytes
// and error counts come from a queue model, and a negedge monitor checks every pop.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int CLK_FREQ   = 3_300_000;
    localparam int BAUDRATE   = 100_000;
    localparam int FIFO_DEPTH = 8;
    localparam int CPB        = CLK_FREQ / BAUDRATE;
    localparam int HALF       = CPB / 2;
    // Edges after the start-bit launch edge at which the stop bit is sampled (2 sync + 1 detect).
    localparam int STOP_EDGE  = 3 + HALF + 9 * CPB;

    logic                        clk = 1'b0;
    logic                        rst_i;
    logic                        ser_rx_i;
    logic [7:0]                  rdata_o;
    logic                        rvalid_o;
    logic                        rready_i;
    logic [$clog2(FIFO_DEPTH):0] level_o;
    logic                        frame_err_o;
    logic                        overrun_o;

    logic [7:0] expQ[$];
    logic [7:0] popExp;
    int nCompared = 0, nMismatch = 0;
    int expFrameErr = 0, expOverrun = 0, frErrCycles = 0, ovrCycles = 0;

    uart_rx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUDRATE  (BAUDRATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .ser_rx_i   (ser_rx_i),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .rready_i   (rready_i),
        .level_o    (level_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    always #20 clk = ~clk;

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop is checked against the head of the model queue.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (rvalid_o && rready_i) begin
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatch++;
                    $display("[TB] FAIL pop_unexpected: got 0x%0h, expected no data at %0t", rdata_o, $time);
                end else begin
                    popExp = expQ.pop_front();
                    compareVal("pop_data", {24'd0, rdata_o}, {24'd0, popExp});
                end
            end
            if (frame_err_o) frErrCycles++;
            if (overrun_o) ovrCycles++;
            if (frame_err_o || overrun_o) compareVal("err_exclusive", {31'd0, frame_err_o & overrun_o}, 0);
        end
    end

    task automatic driveBit(input logic v);
        ser_rx_i = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Model: a good byte is kept unless the FIFO is full with no pop on the stop sample.
    task automatic applyStimulus(input logic [7:0] data, input bit stopBit, input bit popAtStop);
        if (!stopBit) expFrameErr++;
        else if (expQ.size() < FIFO_DEPTH || popAtStop) expQ.push_back(data);
        else expOverrun++;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        driveBit(stopBit);
        if (!stopBit) driveBit(1'b1);
        ser_rx_i = 1'b1;
    endtask

    task automatic checkOutput(input string tag);
        compareVal({tag, ".level"}, {28'd0, level_o}, expQ.size());
        compareVal({tag, ".rvalid"}, {31'd0, rvalid_o}, {31'd0, expQ.size() != 0});
        if (expQ.size() != 0) compareVal({tag, ".head"}, {24'd0, rdata_o}, {24'd0, expQ[0]});
        compareVal({tag, ".frame_err_cycles"}, frErrCycles, expFrameErr);
        compareVal({tag, ".overrun_cycles"}, ovrCycles, expOverrun);
    endtask

    task automatic drain(input int k);
        rready_i = 1'b1;
        repeat (k) @(posedge clk);
        #1;
        rready_i = 1'b0;
    endtask

    initial begin
        #20_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ser_rx_i = 1'b1;
        rready_i = 1'b0;
        rst_i    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compareVal("reset.level", {28'd0, level_o}, 0);
        compareVal("reset.rvalid", {31'd0, rvalid_o}, 0);
        compareVal("reset.rdata", {24'd0, rdata_o}, 0);
        compareVal("reset.frame_err", {31'd0, frame_err_o}, 0);
        compareVal("reset.overrun", {31'd0, overrun_o}, 0);
        rst_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Single byte, including the exact push latency.
        fork
            applyStimulus(8'h68, 1'b1, 1'b0);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1;
                compareVal("t1.rvalid_before_stop", {31'd0, rvalid_o}, 0);
                @(posedge clk);
                #1;
                compareVal("t1.rvalid_after_stop", {31'd0, rvalid_o}, 1);
            end
        join
        checkOutput("t1");
        drain(1);
        checkOutput("t1_drained");

        // Short glitch must not start a frame.
        ser_rx_i = 1'b0;
        repeat (HALF / 2) @(posedge clk);
        #1;
        ser_rx_i = 1'b1;
        repeat (20 * CPB) @(posedge clk);
        #1;
        checkOutput("t2");

        applyStimulus(8'hA5, 1'b0, 1'b0);
        checkOutput("t3");

        // Break: one frame error, then recovery only after the line returns high.
        ser_rx_i = 1'b0;
        expFrameErr++;
        repeat (15 * CPB) @(posedge clk);
        #1;
        ser_rx_i = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        applyStimulus(8'h5A, 1'b1, 1'b0);
        checkOutput("break");
        drain(1);

        for (int b = 1; b <= 9; b++) applyStimulus(8'(b), 1'b1, 1'b0);
        checkOutput("t4_full");
        drain(8);
        checkOutput("t4_drained");

        for (int b = 1; b <= 8; b++) applyStimulus(8'(b), 1'b1, 1'b0);
        fork
            applyStimulus(8'h09, 1'b1, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1;
                rready_i = 1'b1;
                @(posedge clk);
                #1;
                rready_i = 1'b0;
            end
        join
        checkOutput("t5");
        drain(8);
        checkOutput("t5_drained");

        // Reset in the middle of 0x3C with a byte already buffered.
        applyStimulus(8'h11, 1'b1, 1'b0);
        driveBit(1'b0);
        driveBit(1'b0);
        driveBit(1'b0);
        driveBit(1'b1);
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        expQ.delete();
        compareVal("t6.reset_rdata", {24'd0, rdata_o}, 0);
        repeat (2 * CPB) @(posedge clk);
        #1;
        checkOutput("t6_after_reset");
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        checkOutput("t6");
        drain(2);

        for (int n = 0; n < 40; n++) begin
            drain($urandom_range(0, 2));
            applyStimulus(8'($urandom), $urandom_range(0, 7) != 0, 1'b0);
            checkOutput("rand");
        end
        drain(FIFO_DEPTH + 1);
        checkOutput("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
